// File: rtl/calc_pkg.sv
// calc_pkg: shared types and sizing for the calculator operand-entry path.
//   entry_state_t : operand entry FSM states (ENTRY, CONV, DONE)
//   DEF_DIGITS    : default number of decimal digits held
//   DEF_WIDTH     : default binary operand width (matches calculadora A/B)
//   conv_bits()   : shift iterations needed to convert 'digits' BCD digits
package calc_pkg;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        CONV  = 2'd1,
        DONE  = 2'd2
    } entry_state_t;

    localparam int DEF_DIGITS = 6;
    localparam int DEF_WIDTH  = 18;

    // log2(10) ~ 10/3: bits needed to hold the largest 'digits'-digit decimal.
    function automatic int conv_bits(input int digits);
        return (digits * 10 + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_sub3_nibble.sv
// bcd_sub3_nibble: reverse double-dabble correction for one BCD nibble.
//   din  : nibble after the right shift
//   dout : din - 3 when din >= 8, otherwise din
module bcd_sub3_nibble (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = din[3] ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: decimal operand entry. Digits are shifted into a BCD
// buffer (which also drives the display) and, on commit, converted to binary
// by an iterative reverse double-dabble (one shift per cycle, no divider).
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   digit_valid/digit   offered digit (0..9 accepted, >9 flagged)
//   digit_ready         block can take a digit (decoded, not registered)
//   commit / clear      start conversion / discard entry (pulses)
//   backspace           drop last digit (only with BCD_ENTRY_BACKSPACE_EN)
//   bcd_buf             entered digits, least significant in [3:0]
//   digit_count         number of digits held
//   busy                conversion in progress
//   value/value_valid   converted operand and its valid flag
//   overflow            last conversion saturated to all ones
//   bad_digit           one-cycle pulse on an offered digit above 9
//
// Optional feature: define BCD_ENTRY_BACKSPACE_EN to add the backspace port.
module bcd_operand_entry
    import calc_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int WIDTH  = DEF_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          digit_valid,
    input  logic [3:0]                    digit,
    output logic                          digit_ready,
    input  logic                          commit,
    input  logic                          clear,
`ifdef BCD_ENTRY_BACKSPACE_EN
    input  logic                          backspace,
`endif
    output logic [4*DIGITS-1:0]           bcd_buf,
    output logic [$clog2(DIGITS+1)-1:0]   digit_count,
    output logic                          busy,
    output logic [WIDTH-1:0]              value,
    output logic                          value_valid,
    output logic                          overflow,
    output logic                          bad_digit
);

    localparam int CONV_BITS = conv_bits(DIGITS);
    localparam int BW        = 4 * DIGITS;
    localparam int WW        = BW + CONV_BITS;
    localparam int CW        = $clog2(DIGITS + 1);
    localparam int IW        = $clog2(CONV_BITS + 1);

    entry_state_t          state, state_d;
    logic [WW-1:0]         work, work_d, work_sh, work_adj;
    logic [IW-1:0]         iter, iter_d;
    logic [BW-1:0]         bcd_d;
    logic [CW-1:0]         cnt_d;
    logic [WIDTH-1:0]      value_d;
    logic                  vv_d, ovf_d, busy_d, bad_d;
    logic                  digit_take, digit_bad;
    logic [CONV_BITS+WIDTH-1:0] res_ext;
    logic                  res_ovf;

    // One conversion step: shift right, then correct every BCD nibble.
    assign work_sh = work >> 1;
    assign work_adj[CONV_BITS-1:0] = work_sh[CONV_BITS-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        bcd_sub3_nibble u_sub3 (
            .din  (work_sh[CONV_BITS+4*g +: 4]),
            .dout (work_adj[CONV_BITS+4*g +: 4])
        );
    end

    // Zero-extend the binary field so the overflow test works whether
    // CONV_BITS is wider or narrower than WIDTH.
    assign res_ext = {{WIDTH{1'b0}}, work[CONV_BITS-1:0]};
    assign res_ovf = |res_ext[CONV_BITS+WIDTH-1:WIDTH];

    always_comb begin
        case (state)
            ENTRY:   digit_ready = (digit_count < CW'(DIGITS));
            DONE:    digit_ready = 1'b1;
            default: digit_ready = 1'b0;
        endcase
    end

    assign digit_take = digit_valid && digit_ready && (digit <= 4'd9);
    assign digit_bad  = digit_valid && digit_ready && (digit > 4'd9);

    always_comb begin
        state_d = state;
        work_d  = work;
        iter_d  = iter;
        bcd_d   = bcd_buf;
        cnt_d   = digit_count;
        value_d = value;
        vv_d    = value_valid;
        ovf_d   = overflow;
        busy_d  = busy;
        bad_d   = 1'b0;
        if (clear) begin
            state_d = ENTRY;
            bcd_d   = '0;
            cnt_d   = '0;
            value_d = '0;
            vv_d    = 1'b0;
            ovf_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state)
                CONV: begin
                    if (iter == IW'(CONV_BITS)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        vv_d    = 1'b1;
                        ovf_d   = res_ovf;
                        value_d = res_ovf ? {WIDTH{1'b1}} : res_ext[WIDTH-1:0];
                    end else begin
                        work_d = work_adj;
                        iter_d = iter + IW'(1);
                    end
                end
                ENTRY, DONE: begin
                    if (commit) begin
                        state_d = CONV;
                        work_d  = {bcd_buf, {CONV_BITS{1'b0}}};
                        iter_d  = '0;
                        busy_d  = 1'b1;
                        vv_d    = 1'b0;
                    end
`ifdef BCD_ENTRY_BACKSPACE_EN
                    else if (backspace && digit_count != '0) begin
                        bcd_d = bcd_buf >> 4;
                        cnt_d = digit_count - CW'(1);
                        if (state == DONE) begin
                            vv_d    = 1'b0;
                            state_d = ENTRY;
                        end
                    end
`endif
                    else if (digit_take) begin
                        if (state == DONE) begin
                            // first digit after a result starts a fresh entry
                            bcd_d   = {{(BW-4){1'b0}}, digit};
                            cnt_d   = CW'(1);
                            vv_d    = 1'b0;
                            ovf_d   = 1'b0;
                            state_d = ENTRY;
                        end else begin
                            bcd_d = {bcd_buf[BW-5:0], digit};
                            cnt_d = digit_count + CW'(1);
                        end
                    end else if (digit_bad) begin
                        bad_d = 1'b1;
                    end
                end
                default: state_d = ENTRY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ENTRY;
            work        <= '0;
            iter        <= '0;
            bcd_buf     <= '0;
            digit_count <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            bad_digit   <= 1'b0;
        end else begin
            state       <= state_d;
            work        <= work_d;
            iter        <= iter_d;
            bcd_buf     <= bcd_d;
            digit_count <= cnt_d;
            value       <= value_d;
            value_valid <= vv_d;
            overflow    <= ovf_d;
            busy        <= busy_d;
            bad_digit   <= bad_d;
        end
    end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// tb_bcd_operand_entry: directed bench for bcd_operand_entry. Expected
// conversion results are queued at commit time from a decimal model of the
// entered digits and popped when value_valid rises.
module tb_bcd_operand_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        digit_ready;
    logic        commit = 1'b0;
    logic        clear = 1'b0;
`ifdef BCD_ENTRY_BACKSPACE_EN
    logic        backspace = 1'b0;
`endif
    logic [23:0] bcd_buf;
    logic [2:0]  digit_count;
    logic        busy;
    logic [17:0] value;
    logic        value_valid;
    logic        overflow;
    logic        bad_digit;

    bcd_operand_entry dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_ready (digit_ready),
        .commit      (commit),
        .clear       (clear),
`ifdef BCD_ENTRY_BACKSPACE_EN
        .backspace   (backspace),
`endif
        .bcd_buf     (bcd_buf),
        .digit_count (digit_count),
        .busy        (busy),
        .value       (value),
        .value_valid (value_valid),
        .overflow    (overflow),
        .bad_digit   (bad_digit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] v;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_num  = 0;
    int   m_cnt  = 0;
    bit   m_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_num  = 0;
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        tick();
        digit_valid = 1'b0;
        if (d <= 4'd9) begin
            if (m_done) begin
                m_num  = int'(d);
                m_cnt  = 1;
                m_done = 1'b0;
            end else if (m_cnt < 6) begin
                m_num = m_num * 10 + int'(d);
                m_cnt++;
            end
        end
    endtask

    task automatic do_commit();
        exp_t e;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        e.o = (m_num > 262143);
        e.v = e.o ? 18'h3FFFF : m_num[17:0];
        sb.push_back(e);
        m_done = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
    endtask

    // Bounded wait for the result; latency counted from the commit edge.
    task automatic wait_result(input string tag);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!value_valid && cyc < 60) begin
            tick();
            cyc++;
            if (cyc == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd21);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_value"}, 32'(value), 32'(e.v));
            chk({tag, "_ovf"},   32'(overflow), 32'(e.o));
        end else begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // reset: outputs held at reset values while rst is low
        #2;
        chk("rst_bcd",   32'(bcd_buf), 32'd0);
        chk("rst_count", 32'(digit_count), 32'd0);
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_vv",    32'(value_valid), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_bad",   32'(bad_digit), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_ready", 32'(digit_ready), 32'd1);

        // 1,2,3 then commit
        send_digit(4'd1);
        send_digit(4'd2);
        send_digit(4'd3);
        chk("e123_bcd",   32'(bcd_buf), 32'h000123);
        chk("e123_count", 32'(digit_count), 32'(m_cnt));
        do_commit();
        chk("e123_ready_conv", 32'(digit_ready), 32'd0);
        wait_result("e123");
        chk("e123_vv",       32'(value_valid), 32'd1);
        chk("e123_bcd_hold", 32'(bcd_buf), 32'h000123);

        // a digit in DONE starts a fresh entry
        send_digit(4'd2);
        chk("new_vv",    32'(value_valid), 32'd0);
        chk("new_count", 32'(digit_count), 32'd1);
        chk("new_bcd",   32'(bcd_buf), 32'h000002);
        send_digit(4'd6); send_digit(4'd2); send_digit(4'd1);
        send_digit(4'd4); send_digit(4'd3);
        do_commit();
        wait_result("max");

        // clear in DONE resets value
        do_clear();
        chk("clr_value", 32'(value), 32'd0);
        chk("clr_vv",    32'(value_valid), 32'd0);
        send_digit(4'd2); send_digit(4'd6); send_digit(4'd2);
        send_digit(4'd1); send_digit(4'd4); send_digit(4'd4);
        do_commit();
        wait_result("max1");

        // full buffer, seventh digit ignored
        do_clear();
        for (int i = 0; i < 6; i++) send_digit(4'd9);
        chk("full_ready", 32'(digit_ready), 32'd0);
        send_digit(4'd5);
        chk("full_count", 32'(digit_count), 32'd6);
        chk("full_bcd",   32'(bcd_buf), 32'h999999);
        chk("full_nobad", 32'(bad_digit), 32'd0);
        do_commit();
        wait_result("nines");

        // re-run the conversion on the same buffer
        do_commit();
        wait_result("rerun");

        // bad digit
        do_clear();
        send_digit(4'd4);
        send_digit(4'hB);
        chk("bad_pulse", 32'(bad_digit), 32'd1);
        chk("bad_count", 32'(digit_count), 32'd1);
        chk("bad_bcd",   32'(bcd_buf), 32'h000004);
        tick();
        chk("bad_once",  32'(bad_digit), 32'd0);

        // commit and digit together: commit wins, digit dropped
        digit_valid = 1'b1;
        digit = 4'd7;
        do_commit();
        digit_valid = 1'b0;
        wait_result("prio");
        chk("prio_bcd", 32'(bcd_buf), 32'h000004);

        // clear mid-conversion aborts
        do_clear();
        send_digit(4'd4);
        send_digit(4'd5);
        do_commit();
        void'(sb.pop_front());
        repeat (5) tick();
        do_clear();
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_value", 32'(value), 32'd0);
        chk("abort_count", 32'(digit_count), 32'd0);
        chk("abort_ready", 32'(digit_ready), 32'd1);
        begin
            bit rose;
            rose = 1'b0;
            repeat (30) begin
                tick();
                if (value_valid) rose = 1'b1;
            end
            chk("abort_no_vv", 32'(rose), 32'd0);
        end

        // asynchronous reset mid-conversion
        send_digit(4'd4);
        send_digit(4'd5);
        do_commit();
        void'(sb.pop_front());
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_bcd",   32'(bcd_buf), 32'd0);
        chk("arst_count", 32'(digit_count), 32'd0);
        chk("arst_vv",    32'(value_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        tick();

        // commit with no digits converts to 0
        do_commit();
        wait_result("zero");

`ifdef BCD_ENTRY_BACKSPACE_EN
        do_clear();
        send_digit(4'd7);
        send_digit(4'd8);
        backspace = 1'b1;
        tick();
        backspace = 1'b0;
        m_num = m_num / 10;
        m_cnt--;
        chk("bs_bcd", 32'(bcd_buf), 32'h000007);
        send_digit(4'd9);
        do_commit();
        wait_result("bs79");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
